// File: rtl/bit_timer_ctrl_if.sv
// Handshake bundle between the receive FSM (master) and the bit timer (slave).
// Master drives the run request and the configuration. The timer returns
// strobes and status.
interface bit_timer_ctrl_if #(
    parameter int CLK_BITS     = 4,
    parameter int BIT_CNT_BITS = 4
);
    logic                    enable_timer;
    logic [CLK_BITS-1:0]     clks_per_bit;
    logic [CLK_BITS-1:0]     sample_point;
    logic [BIT_CNT_BITS-1:0] num_bits;
    logic                    shift_strobe;
    logic                    packet_done;
    logic                    busy;
    logic [BIT_CNT_BITS-1:0] bit_index;
    logic                    cfg_err;

    modport master (
        output enable_timer, clks_per_bit, sample_point, num_bits,
        input  shift_strobe, packet_done, busy, bit_index, cfg_err
    );

    modport slave (
        input  enable_timer, clks_per_bit, sample_point, num_bits,
        output shift_strobe, packet_done, busy, bit_index, cfg_err
    );
endinterface

// File: rtl/bit_timer_ctrl.sv
// Bit-period sequencer for the serial receive path.
// On start it times N bit periods of P clocks each. It pulses shift_strobe at
// clock S of every period, then pulses packet_done once. It parks in HOLD
// until enable_timer falls, so each enable assertion yields one packet.
module bit_timer_ctrl #(
    parameter int CLK_BITS     = 4,
    parameter int BIT_CNT_BITS = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    bit_timer_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                  state, state_next;

    logic [CLK_BITS-1:0]     clk_cnt;
    logic [BIT_CNT_BITS-1:0] bit_cnt;
    logic [CLK_BITS-1:0]     p_lat;
    logic [CLK_BITS-1:0]     s_lat;
    logic [BIT_CNT_BITS-1:0] n_lat;

    logic                    cfg_legal;
    logic                    strobe;
    logic                    last_clk;
    logic                    do_start;
    logic                    do_clear;

    // Configuration legality: P>=2, 1<=S<=P, N>=1.
    always_comb begin
        cfg_legal = (bus.clks_per_bit >= CLK_BITS'(2))
                 && (bus.sample_point != '0)
                 && (bus.sample_point <= bus.clks_per_bit)
                 && (bus.num_bits != '0);
    end

    // Period-position decode from the registered counters only. The final
    // period is recognised by counting the strobe of the current cycle. This
    // matters when S==P, because then the last strobe and the last clock of
    // the packet coincide.
    always_comb begin
        strobe   = (state == RUN) && (clk_cnt == s_lat);
        last_clk = (clk_cnt == p_lat)
                && (({1'b0, bit_cnt} + {{BIT_CNT_BITS{1'b0}}, strobe})
                    == {1'b0, n_lat});
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic, counter control and outputs. Abort outranks completion.
    always_comb begin
        state_next       = state;
        do_start         = 1'b0;
        do_clear         = 1'b0;
        bus.shift_strobe = strobe;
        bus.packet_done  = 1'b0;
        bus.busy         = 1'b0;
        bus.bit_index    = bit_cnt;
        bus.cfg_err      = 1'b0;
        unique case (state)
            IDLE: begin
                bus.cfg_err = n_rst && bus.enable_timer && !cfg_legal;
                if (bus.enable_timer && cfg_legal) begin
                    state_next = RUN;
                    do_start   = 1'b1;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (!bus.enable_timer) begin
                    state_next = IDLE;
                    do_clear   = 1'b1;
                end else if (last_clk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.packet_done = 1'b1;
                do_clear        = 1'b1;
                state_next      = bus.enable_timer ? HOLD : IDLE;
            end
            HOLD: begin
                if (!bus.enable_timer) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Clock-per-bit counter (1..P rollover) and bit counter with config latch.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            p_lat   <= '0;
            s_lat   <= '0;
            n_lat   <= '0;
        end else if (do_start) begin
            clk_cnt <= CLK_BITS'(1);
            bit_cnt <= '0;
            p_lat   <= bus.clks_per_bit;
            s_lat   <= bus.sample_point;
            n_lat   <= bus.num_bits;
        end else if (do_clear) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else if (state == RUN) begin
            clk_cnt <= (clk_cnt == p_lat) ? CLK_BITS'(1) : clk_cnt + CLK_BITS'(1);
            if (strobe) bit_cnt <= bit_cnt + BIT_CNT_BITS'(1);
        end
    end

endmodule
